// File: rtl/control_d.sv
// control_d: decode-stage control unit for a five-stage RV32I pipeline.
// It decodes op/funct3/funct7b5 from IF/ID and drives ImmSrcD combinationally.
// All execute-side controls are captured in the ID/EX control register.
// That register clears on reset or on a hazard-unit flush.
module control_d (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       FlushE,
  output logic [1:0] ImmSrcD,
  output logic       RegWriteE,
  output logic [1:0] ResultSrcE,
  output logic       MemWriteE,
  output logic       JumpE,
  output logic       BranchE,
  output logic       ALUSrcE,
  output logic [2:0] ALUControlE,
  output logic       IllegalE
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic       w_reg_write;
  logic [1:0] w_imm_src;
  logic       w_alu_src;
  logic       w_mem_write;
  logic [1:0] w_result_src;
  logic       w_branch;
  logic [1:0] w_alu_op;
  logic       w_jump;
  logic       w_illegal_op;
  logic [2:0] w_alu_control;
  logic       w_illegal_f3;
  logic       w_illegal;

  logic       r_reg_write;
  logic [1:0] r_result_src;
  logic       r_mem_write;
  logic       r_jump;
  logic       r_branch;
  logic       r_alu_src;
  logic [2:0] r_alu_control;
  logic       r_illegal;

  // Main decoder: opcode to datapath control fields. Unsupported opcodes decode to all zeros plus the illegal flag.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    w_reg_write  = 1'b0;
    w_imm_src    = 2'b00;
    w_alu_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_result_src = 2'b00;
    w_branch     = 1'b0;
    w_alu_op     = ALUOP_ADD;
    w_jump       = 1'b0;
    w_illegal_op = 1'b0;
    case (op)
      OP_LW: begin
        w_reg_write  = 1'b1;
        w_alu_src    = 1'b1;
        w_result_src = 2'b01;
      end
      OP_SW: begin
        w_imm_src   = 2'b01;
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      OP_R: begin
        w_reg_write = 1'b1;
        w_alu_op    = ALUOP_FUNC;
      end
      OP_BEQ: begin
        w_imm_src = 2'b10;
        w_branch  = 1'b1;
        w_alu_op  = ALUOP_SUB;
      end
      OP_IALU: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_op    = ALUOP_FUNC;
      end
      OP_JAL: begin
        w_reg_write  = 1'b1;
        w_imm_src    = 2'b11;
        w_result_src = 2'b10;
        w_jump       = 1'b1;
      end
      default: w_illegal_op = 1'b1;
    endcase
  end

  // ALU decoder: ALUOp plus function fields select the ALU operation. Unsupported funct3 values flag the instruction illegal.
  always_comb begin
    w_alu_control = ALU_ADD;
    w_illegal_f3  = 1'b0;
    case (w_alu_op)
      ALUOP_SUB:  w_alu_control = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          3'b000:  w_alu_control = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  w_alu_control = ALU_SLT;
          3'b110:  w_alu_control = ALU_OR;
          3'b111:  w_alu_control = ALU_AND;
          default: w_illegal_f3  = 1'b1;
        endcase
      end
      default:    w_alu_control = ALU_ADD;
    endcase
  end

  assign w_illegal = w_illegal_op | w_illegal_f3;
  assign ImmSrcD   = w_imm_src;

  // ID/EX control register: reset wins over flush, and flush wins over load. An illegal instruction enters as a flagged bubble.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      r_reg_write   <= 1'b0;
      r_result_src  <= 2'b00;
      r_mem_write   <= 1'b0;
      r_jump        <= 1'b0;
      r_branch      <= 1'b0;
      r_alu_src     <= 1'b0;
      r_alu_control <= ALU_ADD;
      r_illegal     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge decode together.
      r_reg_write   <= w_reg_write & ~w_illegal;
      r_result_src  <= w_illegal ? 2'b00 : w_result_src;
      r_mem_write   <= w_mem_write & ~w_illegal;
      r_jump        <= w_jump & ~w_illegal;
      r_branch      <= w_branch & ~w_illegal;
      r_alu_src     <= w_alu_src & ~w_illegal;
      r_alu_control <= w_illegal ? ALU_ADD : w_alu_control;
      r_illegal     <= w_illegal;
    end
  end

  assign RegWriteE   = r_reg_write;
  assign ResultSrcE  = r_result_src;
  assign MemWriteE   = r_mem_write;
  assign JumpE       = r_jump;
  assign BranchE     = r_branch;
  assign ALUSrcE     = r_alu_src;
  assign ALUControlE = r_alu_control;
  assign IllegalE    = r_illegal;

endmodule
